arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux_if.sv | 25 ++
 rtl/arb_mux.sv | 82 ++++++++
 tb/tb_arb_mux.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_mux_if.sv
// rtl/arb_mux_if.sv - request/accept and registered-output handshake bundle for arb_mux
interface arb_mux_if #(
   parameter int N = 32,
   parameter int M = 4
);
   localparam int SW = (M > 1) ? $clog2(M) : 1;

   logic [M*N-1:0] in_data;
   logic [M-1:0]   in_valid;
   logic [M-1:0]   in_ready;
   logic [N-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_sel;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_sel
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_sel
   );
endinterface

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - M-channel arbiter (round-robin or fixed priority) into one registered output entry
module arb_mux #(
   parameter int N    = 32,
   parameter int M    = 4,
   parameter int MODE = 1
) (
   input logic       clk,
   input logic       rst_n,
   arb_mux_if.slave  bus_io
);
   localparam int SW = (M > 1) ? $clog2(M) : 1;

   logic [SW-1:0] last_q, last_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [N-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic [SW-1:0] gnt_idx;
   logic          gnt_found;
   logic          load_en;
   logic          xfer;
   logic [M-1:0]  ready;
   int            cand;

   // Search order starts just above the last winner in round-robin mode, at 0 otherwise.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int k = 0; k < M; k++) begin
         cand = (MODE == 0) ? k : (int'(last_q) + 1 + k) % M;
         if (!gnt_found && bus_io.in_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = SW'(cand);
         end
      end
   end

   // rst_n gating keeps in_ready low while reset is held, even though the entry looks empty.
   assign load_en = !valid_q || bus_io.out_ready;
   assign xfer    = rst_n && load_en && gnt_found;

   always_comb begin
      ready = '0;
      if (xfer) begin
         ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (xfer) begin
         data_d  = bus_io.in_data[int'(gnt_idx)*N +: N];
         sel_d   = gnt_idx;
         valid_d = 1'b1;
         last_d  = gnt_idx;
      end else if (bus_io.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= SW'(M - 1);
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign bus_io.in_ready  = ready;
   assign bus_io.out_data  = data_q;
   assign bus_io.out_valid = valid_q;
   assign bus_io.out_sel   = sel_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - randomized and directed bench for arb_mux in both arbitration modes
module tb_arb_mux;
   localparam int N = 8;
   localparam int M = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [M*N-1:0] drv_data;
   logic [M-1:0]   drv_valid;
   logic           drv_ready;

   arb_mux_if #(.N(N), .M(M)) if_fp ();
   arb_mux_if #(.N(N), .M(M)) if_rr ();

   assign if_fp.in_data   = drv_data;
   assign if_fp.in_valid  = drv_valid;
   assign if_fp.out_ready = drv_ready;
   assign if_rr.in_data   = drv_data;
   assign if_rr.in_valid  = drv_valid;
   assign if_rr.out_ready = drv_ready;

   arb_mux #(.N(N), .M(M), .MODE(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus_io(if_fp.slave));
   arb_mux #(.N(N), .M(M), .MODE(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus_io(if_rr.slave));

   int vectors    = 0;
   int miscompares = 0;

   // Reference state per mode: index 0 = fixed priority, 1 = round-robin.
   int           m_last  [2];
   bit           m_valid [2];
   logic [N-1:0] m_data  [2];
   int           m_sel   [2];
   int           exp_gnt [2];

   function automatic int pick(int mode, int last, logic [M-1:0] v);
      for (int d = 1; d <= M; d++) begin
         int c;
         c = mode ? (last + d) % M : d - 1;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [M-1:0] exp_rdy(int md);
      logic [M-1:0] r;
      r = '0;
      if (exp_gnt[md] >= 0) r[exp_gnt[md]] = 1'b1;
      return r;
   endfunction

   function automatic logic [M-1:0] o_rdy(int md);
      return md ? if_rr.in_ready : if_fp.in_ready;
   endfunction
   function automatic logic o_vld(int md);
      return md ? if_rr.out_valid : if_fp.out_valid;
   endfunction
   function automatic logic [N-1:0] o_dat(int md);
      return md ? if_rr.out_data : if_fp.out_data;
   endfunction
   function automatic int o_sel(int md);
      return md ? int'(if_rr.out_sel) : int'(if_fp.out_sel);
   endfunction

   task automatic model_reset();
      for (int md = 0; md < 2; md++) begin
         m_last[md]  = M - 1;
         m_valid[md] = 1'b0;
         m_data[md]  = '0;
         m_sel[md]   = 0;
         exp_gnt[md] = -1;
      end
   endtask

   task automatic drive(logic [M-1:0] v, logic [M*N-1:0] d, logic r);
      drv_valid = v;
      drv_data  = d;
      drv_ready = r;
      #1;
      for (int md = 0; md < 2; md++) begin
         if (!rst_n || (m_valid[md] && !drv_ready)) exp_gnt[md] = -1;
         else exp_gnt[md] = pick(md, m_last[md], drv_valid);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         for (int md = 0; md < 2; md++) begin
            if (exp_gnt[md] >= 0) begin
               m_data[md]  = drv_data[exp_gnt[md]*N +: N];
               m_sel[md]   = exp_gnt[md];
               m_last[md]  = exp_gnt[md];
               m_valid[md] = 1'b1;
            end else if (drv_ready) begin
               m_valid[md] = 1'b0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      drive('0, '0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      drive(4'b1111, 32'h13121110, 1'b1);
      for (int md = 0; md < 2; md++) begin
         vectors++;
         if (o_vld(md) !== 1'b0 || o_dat(md) !== 8'h00 || o_sel(md) != 0 || o_rdy(md) !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs mode=%0d got vld=%b dat=%h sel=%0d rdy=%b want 0/00/0/0000",
                     md, o_vld(md), o_dat(md), o_sel(md), o_rdy(md));
         end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_rotation();
      do_reset();
      drive(4'b1111, 32'h13121110, 1'b1);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 32'h13121110, 1'b1);
         vectors++;
         if (if_rr.out_valid !== 1'b1 || if_rr.out_data !== 8'(8'h10 + k % 4) || int'(if_rr.out_sel) != k % 4) begin
            miscompares++;
            $display("FAIL rotation step=%0d got vld=%b dat=%h sel=%0d want 1/%h/%0d",
                     k, if_rr.out_valid, if_rr.out_data, if_rr.out_sel, 8'h10 + k % 4, k % 4);
         end
         tick();
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive(4'b1010, $urandom(), 1'b1);
         vectors++;
         if (if_fp.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL fixed_grant cycle=%0d got %b want 0010", k, if_fp.in_ready);
         end
         tick();
         vectors++;
         if (int'(if_fp.out_sel) != 1 || if_fp.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_sel cycle=%0d got sel=%0d vld=%b want 1/1", k, if_fp.out_sel, if_fp.out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int xfers;
      do_reset();
      drive(4'b0100, 32'h00A50000, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(4'b1111, 32'h5A5B5C5D, 1'b0);
         vectors++;
         if (if_rr.out_data !== 8'hA5 || if_rr.out_valid !== 1'b1 || if_rr.in_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL backpressure_hold cycle=%0d got dat=%h vld=%b rdy=%b want a5/1/0000",
                     k, if_rr.out_data, if_rr.out_valid, if_rr.in_ready);
         end
         tick();
      end
      xfers = 0;
      for (int k = 0; k < 3; k++) begin
         drive(4'b0000, '0, 1'b1);
         if (if_rr.out_valid === 1'b1 && if_rr.out_data === 8'hA5) xfers++;
         tick();
      end
      vectors++;
      if (xfers != 1) begin
         miscompares++;
         $display("FAIL backpressure_release got %0d transfers of a5 want 1", xfers);
      end
   endtask

   task automatic test_wrap_skip();
      do_reset();
      drive(4'b0100, $urandom(), 1'b1);
      tick();
      drive(4'b0011, 32'h00002211, 1'b1);
      vectors++;
      if (if_rr.in_ready !== 4'b0001) begin
         miscompares++;
         $display("FAIL wrap_first got %b want 0001", if_rr.in_ready);
      end
      tick();
      drive(4'b0011, 32'h00002211, 1'b1);
      vectors++;
      if (if_rr.in_ready !== 4'b0010 || int'(if_rr.out_sel) != 0) begin
         miscompares++;
         $display("FAIL wrap_second got rdy=%b sel=%0d want 0010/0", if_rr.in_ready, if_rr.out_sel);
      end
      tick();
      vectors++;
      if (int'(if_rr.out_sel) != 1 || if_rr.out_data !== 8'h22) begin
         miscompares++;
         $display("FAIL wrap_out got sel=%0d dat=%h want 1/22", if_rr.out_sel, if_rr.out_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(4'b1000, 32'h77000000, 1'b1);
      tick();
      drive(4'b1111, $urandom(), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      for (int md = 0; md < 2; md++) begin
         vectors++;
         if (o_vld(md) !== 1'b0 || o_sel(md) != 0 || o_dat(md) !== 8'h00 || o_rdy(md) !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_async mode=%0d got vld=%b sel=%0d dat=%h rdy=%b want 0/0/00/0000",
                     md, o_vld(md), o_sel(md), o_dat(md), o_rdy(md));
         end
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1111, 32'h44332211, 1'b1);
      for (int md = 0; md < 2; md++) begin
         vectors++;
         if (o_rdy(md) !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant mode=%0d got %b want 0001", md, o_rdy(md));
         end
      end
      tick();
   endtask

   task automatic test_idle_drain();
      int cnt;
      do_reset();
      drive(4'b0001, 32'h000000C3, 1'b1);
      tick();
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         drive(4'b0000, $urandom(), 1'b1);
         if (if_rr.out_valid === 1'b1) cnt++;
         tick();
      end
      vectors++;
      if (cnt != 1) begin
         miscompares++;
         $display("FAIL idle_drain got %0d valid cycles want 1", cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         drive(M'($urandom()), $urandom(), ($urandom() % 4) != 0);
         for (int md = 0; md < 2; md++) begin
            vectors++;
            if (o_rdy(md) !== exp_rdy(md)) begin
               miscompares++;
               $display("FAIL rand_in_ready mode=%0d cycle=%0d got %b want %b", md, k, o_rdy(md), exp_rdy(md));
            end
            vectors++;
            if (o_vld(md) !== m_valid[md]) begin
               miscompares++;
               $display("FAIL rand_out_valid mode=%0d cycle=%0d got %b want %b", md, k, o_vld(md), m_valid[md]);
            end
            if (m_valid[md]) begin
               vectors++;
               if (o_dat(md) !== m_data[md] || o_sel(md) != m_sel[md]) begin
                  miscompares++;
                  $display("FAIL rand_out_word mode=%0d cycle=%0d got %h/%0d want %h/%0d",
                           md, k, o_dat(md), o_sel(md), m_data[md], m_sel[md]);
               end
            end
         end
         tick();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      drv_valid = '0;
      drv_data  = '0;
      drv_ready = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_rotation();
      test_fixed_priority();
      test_backpressure();
      test_wrap_skip();
      test_reset_mid();
      test_idle_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
